// File: rtl/trig_buf_switch_ctrl_pkg.sv
// Shared definitions for the trigger-count buffer-switch controller.
// Entry width grows by a 32-bit timestamp when TRIG_SNAP_TIMESTAMP_EN is defined.
package trig_buf_switch_ctrl_pkg;

    localparam int DEF_NCHAN = 5;
    localparam int DEF_CNT_W = 20;
    localparam int TS_W      = 32;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SNAP  = 2'd2
    } state_e;

    // Entry layout, MSB to LSB: [timestamp,] buffer index, counts, saturation flags
    function automatic int snap_entry_w(input int nbuf, input int nchan, input int cnt_w);
`ifdef TRIG_SNAP_TIMESTAMP_EN
        return $clog2(nbuf) + nchan * (cnt_w + 1) + TS_W;
`else
        return $clog2(nbuf) + nchan * (cnt_w + 1);
`endif
    endfunction

endpackage

// File: rtl/trig_buf_switch_ctrl_snap_fifo.sv
// First-word fall-through synchronous FIFO holding closed-buffer snapshots.
// A pop in the same cycle as a write to a full FIFO frees the slot first.
module trig_buf_switch_ctrl_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [AW:0]      cnt_q;
    logic             do_rd;
    logic             do_wr;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    // Head is forced to zero while empty so the snapshot outputs idle at 0
    assign rd_data_o = empty_o ? '0 : mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wp_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) begin
                wp_q <= wp_q + AW'(1);
            end
            if (do_rd) begin
                rp_q <= rp_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/trig_buf_switch_ctrl.sv
// Per-channel trigger counting across rotating buffers with drained, snapshotted switches.
// Optional TRIG_SNAP_TIMESTAMP_EN adds a cycle timestamp per snapshot on snap_ts.
module trig_buf_switch_ctrl
    import trig_buf_switch_ctrl_pkg::*;
#(
    parameter int NCHAN     = DEF_NCHAN,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int NBUF      = 4,
    parameter int DRAIN_CYC = 4,
    parameter int FIFO_AW   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [NCHAN-1:0]          chan_trig,
    input  logic                      switch_req,
    output logic                      switch_ack,
    output logic [$clog2(NBUF)-1:0]   cur_buf,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [$clog2(NBUF)-1:0]   snap_buf,
    output logic [NCHAN*CNT_W-1:0]    snap_cnt,
    output logic [NCHAN-1:0]          snap_sat,
    output logic                      busy,
    output logic                      ovf_err,
    output logic                      sw_err
`ifdef TRIG_SNAP_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]           snap_ts
`endif
);

    localparam int BUF_W   = $clog2(NBUF);
    localparam int CNT_FW  = NCHAN * CNT_W;
    localparam int ENTRY_W = snap_entry_w(NBUF, NCHAN, CNT_W);
    localparam int DRN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BUF_W-1:0] BUF_LAST = BUF_W'(NBUF - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);

    state_e           state_q;
    logic [DRN_W-1:0] drn_q;
    logic             ack_q;
    logic [BUF_W-1:0] buf_q;
    logic             ovf_q;
    logic             swe_q;

    logic [CNT_W-1:0] cnt_q [NCHAN];
    logic [CNT_W-1:0] cnt_d [NCHAN];
    logic [NCHAN-1:0] sat_q;
    logic [NCHAN-1:0] sat_d;
    logic [CNT_FW-1:0] cnt_flat;

    logic               snap_fire;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign snap_fire = (state_q == ST_SNAP);
    assign pop       = !fifo_empty && snap_ready;
    assign drop      = snap_fire && fifo_full && !pop;

    // Next counts include this cycle's triggers, so the SNAP-cycle trigger lands in the snapshot
    always_comb begin
        sat_d    = sat_q;
        cnt_flat = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (run && chan_trig[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            cnt_flat[i*CNT_W +: CNT_W] = cnt_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q <= '0;
        end else if (snap_fire) begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sat_q <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARMED;
            drn_q   <= '0;
            ack_q   <= 1'b0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            swe_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_ARMED: begin
                    if (switch_req) begin
                        ack_q   <= 1'b1;
                        drn_q   <= DRN_LOAD;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (switch_req) begin
                        swe_q <= 1'b1;
                    end
                    if (drn_q == '0) begin
                        state_q <= ST_SNAP;
                    end else begin
                        drn_q <= drn_q - DRN_W'(1);
                    end
                end
                ST_SNAP: begin
                    if (switch_req) begin
                        swe_q <= 1'b1;
                    end
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end
                    buf_q   <= (buf_q == BUF_LAST) ? '0 : buf_q + BUF_W'(1);
                    state_q <= ST_ARMED;
                end
                default: begin
                    state_q <= ST_ARMED;
                end
            endcase
        end
    end

`ifdef TRIG_SNAP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_cap_q;

    // Captured while switch_ack is high; SNAP always follows at least one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if (ack_q) begin
                ts_cap_q <= ts_cnt_q;
            end
        end
    end

    assign wr_entry = {ts_cap_q, buf_q, cnt_flat, sat_d};
    assign snap_ts  = rd_entry[ENTRY_W-1 -: TS_W];
`else
    assign wr_entry = {buf_q, cnt_flat, sat_d};
`endif

    trig_buf_switch_ctrl_snap_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_snap_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (snap_fire),
        .wr_data_i (wr_entry),
        .rd_en_i   (snap_ready),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign switch_ack = ack_q;
    assign cur_buf    = buf_q;
    assign busy       = (state_q != ST_ARMED);
    assign ovf_err    = ovf_q;
    assign sw_err     = swe_q;
    assign snap_valid = !fifo_empty;
    assign snap_sat   = rd_entry[NCHAN-1:0];
    assign snap_cnt   = rd_entry[NCHAN +: CNT_FW];
    assign snap_buf   = rd_entry[NCHAN + CNT_FW +: BUF_W];

endmodule

// File: tb/tb_trig_buf_switch_ctrl.sv
// Bench for trig_buf_switch_ctrl: directed scenarios plus random traffic against a snapshot-queue model.
module tb_trig_buf_switch_ctrl;

    localparam int NCH   = 5;
    localparam int CW    = 4;
    localparam int NB    = 4;
    localparam int DC    = 4;
    localparam int FAW   = 2;
    localparam int DEPTH = 1 << FAW;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int BW    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [NCH-1:0]    chan_trig;
    logic              switch_req;
    logic              snap_ready;
    logic              switch_ack;
    logic [BW-1:0]     cur_buf;
    logic              snap_valid;
    logic [BW-1:0]     snap_buf;
    logic [NCH*CW-1:0] snap_cnt;
    logic [NCH-1:0]    snap_sat;
    logic              busy;
    logic              ovf_err;
    logic              sw_err;

    trig_buf_switch_ctrl #(
        .NCHAN     (NCH),
        .CNT_W     (CW),
        .NBUF      (NB),
        .DRAIN_CYC (DC),
        .FIFO_AW   (FAW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .chan_trig  (chan_trig),
        .switch_req (switch_req),
        .switch_ack (switch_ack),
        .cur_buf    (cur_buf),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_buf   (snap_buf),
        .snap_cnt   (snap_cnt),
        .snap_sat   (snap_sat),
        .busy       (busy),
        .ovf_err    (ovf_err),
        .sw_err     (sw_err)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counts per channel, a countdown to the snapshot edge, and a bounded queue of snapshots
    typedef struct packed {
        logic [BW-1:0]     b;
        logic [NCH*CW-1:0] cnt;
        logic [NCH-1:0]    sat;
    } snap_t;

    snap_t mq[$];
    int    m_cnt[NCH];
    bit    m_sat[NCH];
    int    m_buf  = 0;
    int    m_left = 0;
    bit    m_ack  = 1'b0;
    bit    m_ovf  = 1'b0;
    bit    m_swe  = 1'b0;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_sat[c] = 1'b0;
        end
        mq.delete();
        m_buf  = 0;
        m_left = 0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_swe  = 1'b0;
    endtask

    task automatic model_step();
        bit    busy_now;
        snap_t s;
        busy_now = (m_left > 0);
        if (mq.size() > 0 && snap_ready) void'(mq.pop_front());
        for (int c = 0; c < NCH; c++) begin
            if (run && chan_trig[c]) begin
                if (m_cnt[c] == MAXC) m_sat[c] = 1'b1;
                else m_cnt[c] = m_cnt[c] + 1;
            end
        end
        m_ack = 1'b0;
        if (busy_now) begin
            if (switch_req) m_swe = 1'b1;
            m_left = m_left - 1;
            if (m_left == 0) begin
                s.b = BW'(m_buf);
                for (int c = 0; c < NCH; c++) begin
                    s.cnt[c*CW +: CW] = CW'(m_cnt[c]);
                    s.sat[c]          = m_sat[c];
                    m_cnt[c] = 0;
                    m_sat[c] = 1'b0;
                end
                if (mq.size() < DEPTH) mq.push_back(s);
                else m_ovf = 1'b1;
                m_buf = (m_buf + 1) % NB;
            end
        end else if (switch_req) begin
            m_left = DC + 1;
            m_ack  = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ack", 64'(switch_ack), 64'(m_ack));
            chk("cur_buf", 64'(cur_buf), 64'(m_buf));
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
            chk("sw_err", 64'(sw_err), 64'(m_swe));
            chk("snap_valid", 64'(snap_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("snap_buf", 64'(snap_buf), 64'(mq[0].b));
                chk("snap_cnt", 64'(snap_cnt), 64'(mq[0].cnt));
                chk("snap_sat", 64'(snap_sat), 64'(mq[0].sat));
            end
        end
    end

    task automatic do_switch(input int wait_cyc);
        switch_req = 1'b1;
        @(negedge clk);
        switch_req = 1'b0;
        repeat (wait_cyc) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nsn;
        rst_n      = 1'b0;
        run        = 1'b0;
        chan_trig  = '0;
        switch_req = 1'b0;
        snap_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(snap_valid), 64'd0);
        chk("rst_cur_buf", 64'(cur_buf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(switch_ack), 64'd0);
        chk("rst_cnt", 64'(snap_cnt), 64'd0);
        chk("rst_errs", 64'({ovf_err, sw_err}), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 3 triggers on ch0, 7 on ch2, then one switch
        run = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chan_trig = (k < 3) ? 5'b00101 : 5'b00100;
            @(negedge clk);
        end
        chan_trig  = '0;
        switch_req = 1'b1;
        @(negedge clk);
        switch_req = 1'b0;
        chk("t1_ack", 64'(switch_ack), 64'd1);
        repeat (5) @(negedge clk);
        chk("t1_valid", 64'(snap_valid), 64'd1);
        chk("t1_buf", 64'(snap_buf), 64'd0);
        chk("t1_cnt", 64'(snap_cnt), 64'h00703);
        chk("t1_sat", 64'(snap_sat), 64'd0);
        chk("t1_cur_buf", 64'(cur_buf), 64'd1);

        // ch1 triggers through the accept, DRAIN, SNAP and first ARMED cycles
        chan_trig = 5'b00010;
        do_switch(5);
        chk("t2_buf", 64'(snap_buf), 64'd1);
        chk("t2_cnt", 64'(snap_cnt), 64'h00060);
        @(negedge clk);
        chan_trig = '0;
        do_switch(5);
        chk("t2_new_buf", 64'(snap_buf), 64'd2);
        chk("t2_new_cnt", 64'(snap_cnt), 64'h00010);

        // Five switches with the consumer stalled: the fifth is dropped
        pulse_reset();
        rst_n      = 1'b1;
        run        = 1'b0;
        snap_ready = 1'b0;
        for (int j = 0; j < 5; j++) do_switch(6);
        chk("t3_ovf", 64'(ovf_err), 64'd1);
        chk("t3_cur_buf", 64'(cur_buf), 64'd1);
        for (int j = 0; j < 4; j++) begin
            chk("t3_valid", 64'(snap_valid), 64'd1);
            chk("t3_order", 64'(snap_buf), 64'(j));
            snap_ready = 1'b1;
            @(negedge clk);
        end
        chk("t3_empty", 64'(snap_valid), 64'd0);

        // Second request during DRAIN is rejected
        chk("t4_swerr0", 64'(sw_err), 64'd0);
        switch_req = 1'b1;
        @(negedge clk);
        switch_req = 1'b0;
        chk("t4_ack", 64'(switch_ack), 64'd1);
        @(negedge clk);
        switch_req = 1'b1;
        @(negedge clk);
        switch_req = 1'b0;
        chk("t4_noack", 64'(switch_ack), 64'd0);
        chk("t4_swerr", 64'(sw_err), 64'd1);
        nsn = 0;
        for (int k = 0; k < 10; k++) begin
            if (snap_valid) nsn++;
            @(negedge clk);
        end
        chk("t4_nsnap", 64'(nsn), 64'd1);

        // Saturation on ch3, then a fresh buffer restarts from zero
        run       = 1'b1;
        chan_trig = 5'b01000;
        repeat (20) @(negedge clk);
        chan_trig = '0;
        do_switch(5);
        chk("t5_cnt", 64'(snap_cnt), 64'h0F000);
        chk("t5_sat", 64'(snap_sat), 64'h08);
        chan_trig = 5'b01000;
        repeat (2) @(negedge clk);
        chan_trig = '0;
        do_switch(5);
        chk("t5_new_cnt", 64'(snap_cnt), 64'h02000);
        chk("t5_new_sat", 64'(snap_sat), 64'd0);

        // Reset while in DRAIN with two snapshots queued
        snap_ready = 1'b0;
        chan_trig  = 5'b11111;
        do_switch(6);
        do_switch(6);
        do_switch(1);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_valid", 64'(snap_valid), 64'd1);
        pulse_reset();
        chk("t6_valid0", 64'(snap_valid), 64'd0);
        chk("t6_cur_buf", 64'(cur_buf), 64'd0);
        chk("t6_busy0", 64'(busy), 64'd0);
        chk("t6_errs", 64'({ovf_err, sw_err}), 64'd0);
        rst_n      = 1'b1;
        chan_trig  = '0;
        snap_ready = 1'b1;
        do_switch(5);
        chk("t6_snap_valid", 64'(snap_valid), 64'd1);
        chk("t6_snap_buf", 64'(snap_buf), 64'd0);
        chk("t6_snap_cnt", 64'(snap_cnt), 64'd0);
        chk("t6_snap_sat", 64'(snap_sat), 64'd0);

        // Random traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                pulse_reset();
                rst_n = 1'b1;
            end
            run        = ($urandom_range(0, 9) != 0);
            chan_trig  = 5'($urandom);
            switch_req = ($urandom_range(0, 7) == 0);
            snap_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
